// File: rtl/xs3_digit_entry.sv
// Excess-3 keypad digit entry: debounces the encoder code, detects each new press,
// and shifts the BCD digit into a multi-digit entry register with strobe/overflow/err pulses.
module xs3_digit_entry #(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            xs3_in,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [2:0]            digit_cnt,
    output logic                  key_valid,
    output logic                  overflow,
    output logic                  err
);

    localparam int               W        = 4 * DIGITS;
    localparam int               CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]    DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [2:0]       DIG_MAX  = 3'(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEB  = 2'd1,
        S_HOLD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    function automatic logic is_legal(input logic [3:0] code);
        return (code >= 4'd3) && (code <= 4'd12);
    endfunction

    function automatic logic is_illegal(input logic [3:0] code);
        return (code != 4'd0) && !is_legal(code);
    endfunction

    state_t          state_r, state_s;
    logic [3:0]      latch_r, latch_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            accept_s;
    logic            legal_s;
    logic [3:0]      digit_s;
    logic [W-1:0]    bcd_r;
    logic [2:0]      dcnt_r;
    logic            key_valid_r;
    logic            overflow_r;
    logic            err_r;

    // FSM state, latched code and debounce/release counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            latch_r <= 4'd0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            latch_r <= latch_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; one counter serves both press debounce and release debounce
    always_comb begin
        state_s  = state_r;
        latch_s  = latch_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        legal_s  = is_legal(xs3_in);
        case (state_r)
            S_IDLE: begin
                if (legal_s) begin
                    latch_s = xs3_in;
                    cnt_s   = CNT_ONE;
                    if (DEBOUNCE == 1) begin
                        accept_s = 1'b1;
                        state_s  = S_HOLD;
                    end else begin
                        state_s  = S_DEB;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_DEB: begin
                if (legal_s && (xs3_in == latch_r)) begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == DEB_LAST) begin
                        accept_s = 1'b1;
                        state_s  = S_HOLD;
                    end else begin
                        state_s  = S_DEB;
                    end
                end else begin
                    cnt_s   = {CW{1'b0}};
                    state_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!legal_s) begin
                    cnt_s   = CNT_ONE;
                    state_s = (DEBOUNCE == 1) ? S_IDLE : S_REL;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_REL: begin
                if (!legal_s) begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == DEB_LAST) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_REL;
                    end
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    assign digit_s = latch_s - 4'd3;

    // Entry register and output pulses; clear wins over a same-edge accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_r       <= {W{1'b0}};
            dcnt_r      <= 3'd0;
            key_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            err_r       <= is_illegal(xs3_in);
            if (clear) begin
                bcd_r  <= {W{1'b0}};
                dcnt_r <= 3'd0;
            end else if (accept_s) begin
                if (dcnt_r < DIG_MAX) begin
                    bcd_r       <= (bcd_r << 4) | W'(digit_s);
                    dcnt_r      <= dcnt_r + 3'd1;
                    key_valid_r <= 1'b1;
                end else begin
                    overflow_r  <= 1'b1;
                end
            end
        end
    end

    assign bcd_out   = bcd_r;
    assign digit_cnt = dcnt_r;
    assign key_valid = key_valid_r;
    assign overflow  = overflow_r;
    assign err       = err_r;

endmodule

// File: tb/tb_xs3_digit_entry.sv
// Directed bench for xs3_digit_entry (DIGITS=4, DEBOUNCE=4) with hand-computed expectations.
module tb_xs3_digit_entry;

    logic        clk;
    logic        rst;
    logic [3:0]  xs3_in;
    logic        clear;
    logic [15:0] bcd_out;
    logic [2:0]  digit_cnt;
    logic        key_valid;
    logic        overflow;
    logic        err;

    int errors = 0;
    int checks = 0;

    xs3_digit_entry #(.DIGITS(4), .DEBOUNCE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .xs3_in    (xs3_in),
        .clear     (clear),
        .bcd_out   (bcd_out),
        .digit_cnt (digit_cnt),
        .key_valid (key_valid),
        .overflow  (overflow),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_entry(input string tag, input logic [15:0] ebcd, input logic [2:0] ecnt);
        chk({tag, ".bcd"}, 32'(bcd_out), 32'(ebcd));
        chk({tag, ".cnt"}, 32'(digit_cnt), 32'(ecnt));
    endtask

    // One clock with the given code, then check the three pulse outputs
    task automatic step(input logic [3:0] code, input logic ekv, input logic eov, input logic eerr);
        xs3_in = code;
        @(posedge clk);
        #1;
        chk("key_valid", 32'(key_valid), 32'(ekv));
        chk("overflow", 32'(overflow), 32'(eov));
        chk("err", 32'(err), 32'(eerr));
    endtask

    // Hold a code four edges (accept on the 4th), then release for four edges
    task automatic press(input logic [3:0] code, input logic kv4, input logic ov4);
        for (int i = 0; i < 3; i++) step(code, 1'b0, 1'b0, 1'b0);
        step(code, kv4, ov4, 1'b0);
        for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        xs3_in = 4'd0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk_entry("clear", 16'h0000, 3'd0);
    endtask

    initial begin
        rst    = 1'b1;
        clear  = 1'b0;
        xs3_in = 4'd0;
        #12;
        chk_entry("reset", 16'h0000, 3'd0);
        chk("reset.kv", 32'(key_valid), 32'd0);
        chk("reset.ov", 32'(overflow), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
        chk_entry("idle", 16'h0000, 3'd0);

        // code 8 held 6 cycles then released 6
        for (int i = 0; i < 3; i++) step(4'd8, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b1, 1'b0, 1'b0);
        chk_entry("first8", 16'h0005, 3'd1);
        for (int i = 0; i < 2; i++) step(4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
        press(4'd8, 1'b1, 1'b0);
        chk_entry("second8", 16'h0055, 3'd2);

        // bounce: 4,4,0 aborts, then four consecutive 4s accept
        do_clear();
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd4, 1'b1, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
        chk_entry("bounce", 16'h0001, 3'd1);

        // fill all four digits, then overflow
        do_clear();
        press(4'd4, 1'b1, 1'b0);
        press(4'd5, 1'b1, 1'b0);
        chk_entry("two", 16'h0012, 3'd2);
        press(4'd6, 1'b1, 1'b0);
        press(4'd7, 1'b1, 1'b0);
        chk_entry("full", 16'h1234, 3'd4);
        press(4'd12, 1'b0, 1'b1);
        chk_entry("overflow", 16'h1234, 3'd4);

        // illegal codes
        step(4'd14, 1'b0, 1'b0, 1'b1);
        step(4'd14, 1'b0, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b0, 1'b0);
        chk_entry("illegal", 16'h1234, 3'd4);
        do_clear();
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b0, 1'b0, 1'b0);
        step(4'd14, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
        chk_entry("abort", 16'h0000, 3'd0);

        // clear on the accept edge of code 9
        press(4'd4, 1'b1, 1'b0);
        chk_entry("pre9", 16'h0001, 3'd1);
        for (int i = 0; i < 3; i++) step(4'd9, 1'b0, 1'b0, 1'b0);
        clear = 1'b1;
        step(4'd9, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        chk_entry("clr_acc", 16'h0000, 3'd0);
        for (int i = 0; i < 6; i++) step(4'd9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
        chk_entry("held9", 16'h0000, 3'd0);
        press(4'd9, 1'b1, 1'b0);
        chk_entry("new9", 16'h0006, 3'd1);

        // async reset mid-cycle while debouncing code 5
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_entry("async_rst", 16'h0000, 3'd0);
        chk("async_rst.kv", 32'(key_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
        chk_entry("post_rst", 16'h0000, 3'd0);
        press(4'd3, 1'b1, 1'b0);
        chk_entry("post_rst0", 16'h0000, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
